// File: rtl/riscv_m_pkg.sv
// rtl/riscv_m_pkg.sv - shared encodings for the RV32M multiply/divide unit
package riscv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // MUL only keeps the low half, so it is computed unsigned.
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// rtl/riscv_muldiv_unit_if.sv - request/response bundle between control FSM and muldiv unit
interface riscv_muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, input busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - radix-2 shift-add multiply / restoring divide shift register
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_abs,
  input  logic [XLEN-1:0]   b_abs,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN-1:0]   opnd;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits then quotient bits}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, opnd};
    div_next = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{XLEN{1'b0}}, a_abs};
      opnd <= b_abs;
    end else if (step) begin
      acc  <= is_div ? div_next : mul_next;
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - iterative RV32M multiply/divide unit for the execute stage
module riscv_muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  riscv_muldiv_unit_if.slave  mdu
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3_q;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   result_q;

  logic              accept, special, b_zero, div_ovf;
  logic              sa_in, sb_in;
  logic [XLEN-1:0]   abs_a, abs_b, special_val;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   quo, rem, fin_val;

  always_comb begin
    accept  = mdu.start && ((state == ST_IDLE) || (state == ST_DONE));
    sa_in   = op_signed_a(mdu.funct3) & mdu.op_a[XLEN-1];
    sb_in   = op_signed_b(mdu.funct3) & mdu.op_b[XLEN-1];
    abs_a   = sa_in ? -mdu.op_a : mdu.op_a;
    abs_b   = sb_in ? -mdu.op_b : mdu.op_b;
    b_zero  = (mdu.op_b == '0);
    div_ovf = ((mdu.funct3 == F3_DIV) || (mdu.funct3 == F3_REM)) &&
              (mdu.op_a == INT_MIN) && (&mdu.op_b);
    special = mdu.funct3[2] && (b_zero || div_ovf);
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (b_zero)
      special_val = mdu.funct3[1] ? mdu.op_a : {XLEN{1'b1}};
    else
      special_val = mdu.funct3[1] ? {XLEN{1'b0}} : INT_MIN;
  end

  always_comb begin
    prod = (sign_a ^ sign_b) ? -acc : acc;
    quo  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                        fin_val = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fin_val = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fin_val = quo;
      default:                       fin_val = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mdu.busy   = 1'b0;
    mdu.done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        mdu.busy = 1'b1;
        if (cnt == CNT_LAST) state_next = ST_FIN;
      end
      ST_FIN: begin
        mdu.busy   = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        mdu.done = 1'b1;
        if (accept) state_next = special ? ST_DONE : ST_CALC;
        else        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Special cases bypass the datapath, so their result is captured at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      f3_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        f3_q   <= mdu.funct3;
        sign_a <= sa_in;
        sign_b <= sb_in;
        cnt    <= '0;
      end else if (state == ST_CALC) begin
        cnt <= cnt + CW'(1);
      end
      if (accept && special)   result_q <= special_val;
      else if (state == ST_FIN) result_q <= fin_val;
    end
  end

  assign mdu.result = result_q;

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state == ST_CALC),
    .is_div (f3_q[2]),
    .a_abs  (abs_a),
    .b_abs  (abs_b),
    .acc    (acc)
  );

endmodule
